ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the decode/control-generation stage.
- Owns the PC and issues one-outstanding word fetches to instruction memory over a valid/ready request plus valid-only response.
- Holds each fetched instruction in an output register and presents it to decode under a valid/ready handshake, with the opcode/func3/func7 fields pre-split.
- Accepts PC redirects from execute (branch/jump) and discards stale fetches.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- XLEN, 32, PC/address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (word aligned)
- imem_rsp_valid  in  1  response data valid; never back-pressured
- imem_rsp_data  in  32  fetched instruction word
- redirect_valid  in  1  PC redirect from execute
- redirect_pc  in  XLEN  redirect target
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  held instruction
- inst_pc  out  XLEN  PC of held instruction
- opcode  out  7  inst[6:0]
- func3  out  3  inst[14:12]
- func7  out  7  inst[31:25]
- fetch_cnt  out  32  count of instructions accepted by decode

Behaviour:
- Reset is synchronous and active-high on clk. After the reset edge:
  - state=REQ, pc=RESET_PC, imem_req_valid=1, imem_req_addr=RESET_PC;
  - inst_valid=0, inst=0, inst_pc=0, opcode/func3/func7=0, fetch_cnt=0.
- Reset mid-operation abandons any outstanding request. A response arriving after reset is ignored only if it comes while the state is REQ; memory is reset together with this block.
- States: REQ, WAIT, HOLD, FLUSH. At most one request is outstanding. Response latency is >=1 cycle after request acceptance.
- Outputs:
  - imem_req_valid=(state==REQ); imem_req_addr=pc with bits[1:0] forced 0.
  - inst_valid=(state==HOLD).
  - inst, inst_pc, opcode, func3 and func7 are register-driven and stable whenever inst_valid=1.
- Transitions (redirect_valid has priority over every other event in that cycle):
  - REQ:
    - req handshake and no redirect -> WAIT.
    - req handshake and redirect -> pc<=redirect_pc, FLUSH (the old request is in flight).
    - redirect without handshake -> pc<=redirect_pc, stay REQ.
  - WAIT:
    - rsp_valid and no redirect -> inst<=rsp_data, inst_pc<=pc, HOLD.
    - rsp_valid and redirect -> drop data, pc<=redirect_pc, REQ.
    - redirect without rsp -> pc<=redirect_pc, FLUSH.
  - HOLD:
    - inst_valid and inst_ready and no redirect -> pc<=pc+4, fetch_cnt+=1, REQ.
    - redirect -> pc<=redirect_pc, REQ. The instruction is discarded and fetch_cnt is unchanged, even if inst_ready=1 that cycle.
    - otherwise hold all outputs.
  - FLUSH:
    - rsp_valid -> discard data, REQ.
    - redirect -> pc<=redirect_pc, stay FLUSH unless rsp_valid in the same cycle (then REQ with the new pc).
- Arithmetic:
  - pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
  - fetch_cnt wraps 32'hFFFF_FFFF -> 0.
  - redirect_pc bits[1:0] are ignored.
- Throughput: best case 3 cycles per instruction (REQ, WAIT with same-next-cycle response, HOLD with inst_ready=1).
- imem_rsp_valid in REQ or HOLD is a protocol violation. The block ignores it; the bench flags it.

Test Plan:
- Reset then memory with 1-cycle latency, inst_ready=1 -> requests to 8000_0000, 8000_0004, 8000_0008. Each inst_valid appears 2 cycles after its request handshake. fetch_cnt=3 after the third accept.
- Hold inst_ready=0 for 5 cycles in HOLD with inst=32'h00500093 -> inst, inst_pc=8000_0000, opcode=7'h13, func3=0, func7=0 stable; imem_req_valid=0; no new request. Release -> next addr 8000_0004.
- imem_req_ready=0 for 4 cycles -> imem_req_valid and addr held. Redirect to 8000_0100 during the stall -> next accepted address 8000_0100.
- Redirect to 8000_0200 in WAIT with 3-cycle latency -> FLUSH. The stale response is not presented (inst_valid stays 0). The next request is 8000_0200.
- Redirect in HOLD with inst_ready=1 same cycle -> the instruction is not counted (fetch_cnt unchanged). The next request is the redirect target, with bits[1:0] cleared for target 8000_0302 -> 8000_0300.
- Redirect to FFFF_FFFC then accept -> next request address 0000_0000. Assert rst while in WAIT -> next cycle REQ at RESET_PC, inst_valid=0, fetch_cnt=0.

Source files
------------

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch -- instruction fetch stage feeding decode.
//
// Owns the PC, issues one outstanding word fetch at a time to instruction
// memory, parks the returned word in an output register and hands it to
// decode with a valid/ready handshake. Redirects from execute replace the PC
// and cause any in-flight fetch to be dropped.
//
// Ports:
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   imem_req_valid/ready/addr   fetch request (word-aligned address)
//   imem_rsp_valid/data         fetch response, never back-pressured
//   redirect_valid/pc           PC redirect from execute (bits[1:0] ignored)
//   inst_valid/ready            instruction handshake towards decode
//   inst, inst_pc               held instruction and its PC
//   opcode, func3, func7        pre-split fields of inst
//   fetch_cnt                   instructions accepted by decode (wraps)
// ---------------------------------------------------------------------------
module ifu_fetch #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic [6:0]      opcode,
   output logic [2:0]      func3,
   output logic [6:0]      func7,
   output logic [31:0]     fetch_cnt
);

   // FLUSH means a request is still in flight whose data must be thrown away.
   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

   state_t          state_reg, state_next;
   logic [XLEN-1:0] pc_reg, pc_next;
   logic [31:0]     inst_reg, inst_next;
   logic [XLEN-1:0] inst_pc_reg, inst_pc_next;
   logic [31:0]     fetch_cnt_reg, fetch_cnt_next;

   logic [XLEN-1:0] redirect_target;
   logic [XLEN-1:0] fetch_addr;

   assign redirect_target = redirect_pc & ALIGN_MASK;
   assign fetch_addr      = pc_reg & ALIGN_MASK;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_REQ;
         pc_reg        <= RESET_PC;
         inst_reg      <= '0;
         inst_pc_reg   <= '0;
         fetch_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         inst_reg      <= inst_next;
         inst_pc_reg   <= inst_pc_next;
         fetch_cnt_reg <= fetch_cnt_next;
      end
   end

   // A redirect wins over every other event in the same cycle.
   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      inst_next      = inst_reg;
      inst_pc_next   = inst_pc_reg;
      fetch_cnt_next = fetch_cnt_reg;

      case (state_reg)
         S_REQ: begin
            if (redirect_valid) begin
               pc_next = redirect_target;
               // An accepted request is already out; its data must be dropped.
               if (imem_req_ready) begin
                  state_next = S_FLUSH;
               end
            end else if (imem_req_ready) begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_next    = redirect_target;
               state_next = imem_rsp_valid ? S_REQ : S_FLUSH;
            end else if (imem_rsp_valid) begin
               inst_next    = imem_rsp_data;
               inst_pc_next = fetch_addr;
               state_next   = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               // The held instruction is discarded and never counted.
               pc_next    = redirect_target;
               state_next = S_REQ;
            end else if (inst_ready) begin
               pc_next        = pc_reg + XLEN'(4);
               fetch_cnt_next = fetch_cnt_reg + 32'd1;
               state_next     = S_REQ;
            end
         end
         S_FLUSH: begin
            if (redirect_valid) begin
               pc_next = redirect_target;
            end
            if (imem_rsp_valid) begin
               state_next = S_REQ;
            end
         end
         default: begin
            state_next = S_REQ;
         end
      endcase
   end

   assign imem_req_valid = (state_reg == S_REQ);
   assign imem_req_addr  = fetch_addr;
   assign inst_valid     = (state_reg == S_HOLD);
   assign inst           = inst_reg;
   assign inst_pc        = inst_pc_reg;
   assign opcode         = inst_reg[6:0];
   assign func3          = inst_reg[14:12];
   assign func7          = inst_reg[31:25];
   assign fetch_cnt      = fetch_cnt_reg;

endmodule
